// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//   Avalon-MM slave bus plus interrupt line of the PWM capture block.
//   chipselect  select for this slave
//   address     word address: 0 HIGH_CNT, 1 PERIOD_CNT, 2 STATUS, 3 CONTROL
//   read        read strobe, zero read latency
//   write       write strobe
//   writedata   write data
//   readdata    read data, combinational from address
//   irq         level interrupt
interface pwm_capture_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output chipselect, address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  chipselect, address, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures high time and period of an external PWM signal in clk cycles and
//   exposes the coherent result pair, status flags and control bits on an
//   Avalon-MM slave. Flags a stalled input (timeout) and unread results
//   (overrun); optional level interrupt.
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   pwm_in   asynchronous PWM input
//   bus      Avalon-MM slave (chipselect/address/read/write/writedata/readdata) + irq
// Parameters
//   CNT_W    width of counter and results
//   TIMEOUT  cycles without the expected edge before timeout, <= 2^CNT_W-1
module pwm_capture #(
    parameter int unsigned CNT_W   = 21,
    parameter int unsigned TIMEOUT = 2_000_000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pwm_in,
    pwm_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    // input conditioning
    logic pwm_meta;
    logic pwm_s;
    logic pwm_d;
    logic rise;
    logic fall;

    // measurement
    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  hi_tmp;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              load_hi;
    logic              capture;
    logic              timeout_evt;

    // registers
    logic        valid;
    logic        timeout_flag;
    logic        overrun;
    logic        ctrl_enable;
    logic        ctrl_irq_en;
    logic        irq_q;
    logic        wr_status;
    logic        wr_ctrl;
    logic [31:0] rd_data;
    logic        unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_meta <= 1'b0;
            pwm_s    <= 1'b0;
            pwm_d    <= 1'b0;
        end else begin
            pwm_meta <= pwm_in;
            pwm_s    <= pwm_meta;
            pwm_d    <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_d;
    assign fall = ~pwm_s & pwm_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The qualifying edge is tested before the timeout compare, so an edge
    // arriving exactly at cnt == TIMEOUT still counts as a valid measurement.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_hi     = 1'b0;
        capture     = 1'b0;
        timeout_evt = 1'b0;
        if (!ctrl_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (fall) begin
                        load_hi = 1'b1;
                        state_d = ST_LOW;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        timeout_evt = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_LOW: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (rise) begin
                        capture = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_HIGH;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        timeout_evt = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // High time is parked in hi_tmp and only published together with the
    // period so software always reads a matching pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_tmp     <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
        end else begin
            if (load_hi) begin
                hi_tmp <= cnt_q;
            end
            if (capture) begin
                high_cnt   <= hi_tmp;
                period_cnt <= cnt_q;
            end
        end
    end

    assign wr_status = bus.chipselect & bus.write & (bus.address == 2'd2);
    assign wr_ctrl   = bus.chipselect & bus.write & (bus.address == 2'd3);

    // Set terms are OR-ed after the clear so a same-cycle event wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid        <= 1'b0;
            timeout_flag <= 1'b0;
            overrun      <= 1'b0;
            ctrl_enable  <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            valid        <= capture     | (valid        & ~(wr_status & bus.writedata[0]));
            timeout_flag <= timeout_evt | (timeout_flag & ~(wr_status & bus.writedata[1]));
            overrun      <= (capture & valid) | (overrun & ~(wr_status & bus.writedata[2]));
            if (wr_ctrl) begin
                ctrl_enable <= bus.writedata[0];
                ctrl_irq_en <= bus.writedata[1];
            end
            irq_q <= ctrl_irq_en & (valid | timeout_flag);
        end
    end

    always_comb begin
        rd_data = '0;
        if (bus.chipselect && bus.read) begin
            case (bus.address)
                2'd0: rd_data = 32'(high_cnt);
                2'd1: rd_data = 32'(period_cnt);
                2'd2: rd_data = {29'd0, overrun, timeout_flag, valid};
                2'd3: rd_data = {30'd0, ctrl_irq_en, ctrl_enable};
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.readdata = rd_data;
    assign bus.irq      = irq_q;

    assign unused_wdata = ^bus.writedata[31:3];

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Directed sequences, a table of pulse shapes and a randomized run, all
//   checked against an edge-timestamp reference model of the measurement.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned TIMEOUT = 2000;

    logic clk = 1'b0;
    logic reset_n;
    logic pwm_in;

    pwm_capture_if bus();

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pwm_in  (pwm_in),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd_last [4];

    // ---------------- reference model ----------------
    // Edges are timestamped; an input change seen at edge n acts at edge n+2.
    // High time = fall stamp - rise stamp, period = rise stamp - previous rise.
    int               m_e;
    logic [3:0]       m_hist;
    logic             m_armed;
    logic             m_in_high;
    int               m_rise_e;
    int               m_fall_e;
    logic [CNT_W-1:0] m_hi;
    logic [CNT_W-1:0] m_per;
    logic             m_valid, m_to, m_ovr, m_en, m_irqen, m_irq;

    always @(posedge clk or negedge reset_n) begin : mdl
        logic [3:0] h;
        logic       r, f, cap, tout, armed_n, in_high_n;
        int         rise_n, fall_n;
        logic [CNT_W-1:0] hi_n, per_n;
        logic [2:0] clr;
        if (!reset_n) begin
            m_e <= 0; m_hist <= '0; m_armed <= 1'b0; m_in_high <= 1'b0;
            m_rise_e <= 0; m_fall_e <= 0; m_hi <= '0; m_per <= '0;
            m_valid <= 1'b0; m_to <= 1'b0; m_ovr <= 1'b0;
            m_en <= 1'b0; m_irqen <= 1'b0; m_irq <= 1'b0;
        end else begin
            h = {m_hist[2:0], pwm_in};
            r = h[2] & ~h[3];
            f = ~h[2] & h[3];
            cap = 1'b0; tout = 1'b0;
            armed_n = m_armed; in_high_n = m_in_high;
            rise_n = m_rise_e; fall_n = m_fall_e;
            hi_n = m_hi; per_n = m_per;
            if (!m_en) begin
                armed_n = 1'b0;
            end else if (r) begin
                if (m_armed && !m_in_high) begin
                    cap   = 1'b1;
                    hi_n  = CNT_W'(m_fall_e - m_rise_e);
                    per_n = CNT_W'(m_e - m_rise_e);
                end
                armed_n = 1'b1; in_high_n = 1'b1; rise_n = m_e;
            end else if (m_armed && m_in_high && f) begin
                in_high_n = 1'b0; fall_n = m_e;
            end else if (m_armed && (m_e - m_rise_e == int'(TIMEOUT))) begin
                tout = 1'b1; armed_n = 1'b0;
            end
            clr = (bus.chipselect && bus.write && bus.address == 2'd2) ? bus.writedata[2:0] : 3'b000;
            m_irq   <= m_irqen & (m_valid | m_to);
            m_valid <= cap | (m_valid & ~clr[0]);
            m_to    <= tout | (m_to & ~clr[1]);
            m_ovr   <= (cap & m_valid) | (m_ovr & ~clr[2]);
            if (bus.chipselect && bus.write && bus.address == 2'd3) begin
                m_en    <= bus.writedata[0];
                m_irqen <= bus.writedata[1];
            end
            m_hist <= h; m_e <= m_e + 1;
            m_armed <= armed_n; m_in_high <= in_high_n;
            m_rise_e <= rise_n; m_fall_e <= fall_n;
            m_hi <= hi_n; m_per <= per_n;
        end
    end

    function automatic logic [31:0] exp_rd(input int a);
        case (a)
            0: return 32'(m_hi);
            1: return 32'(m_per);
            2: return {29'd0, m_ovr, m_to, m_valid};
            default: return {30'd0, m_irqen, m_en};
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        tick();
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 4; a++) begin
            bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 2'(a);
            #1;
            rd_last[a] = bus.readdata;
            check($sformatf("%s_reg%0d", tag, a), bus.readdata, exp_rd(a));
        end
        bus.read = 1'b0; bus.address = 2'd2;
        #1;
        check($sformatf("%s_rd_idle", tag), bus.readdata, 32'd0);
        bus.chipselect = 1'b0;
        check($sformatf("%s_irq", tag), {31'd0, bus.irq}, {31'd0, m_irq});
    endtask

    task automatic pwm_period(input int hi, input int lo);
        pwm_in = 1'b1;
        repeat (hi) tick();
        pwm_in = 1'b0;
        repeat (lo) tick();
    endtask

    typedef struct {
        int hi;
        int lo;
        logic [31:0] exp_high;
        logic [31:0] exp_period;
    } pulse_vec_t;

    pulse_vec_t vecs [6];

    initial begin
        vecs[0] = '{hi: 75,   lo: 925, exp_high: 32'd75,   exp_period: 32'd1000};
        vecs[1] = '{hi: 1,    lo: 49,  exp_high: 32'd1,    exp_period: 32'd50};
        vecs[2] = '{hi: 1,    lo: 1,   exp_high: 32'd1,    exp_period: 32'd2};
        vecs[3] = '{hi: 3,    lo: 2,   exp_high: 32'd3,    exp_period: 32'd5};
        vecs[4] = '{hi: 1999, lo: 1,   exp_high: 32'd1999, exp_period: 32'd2000};
        vecs[5] = '{hi: 40,   lo: 7,   exp_high: 32'd40,   exp_period: 32'd47};

        reset_n = 1'b0; pwm_in = 1'b0;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = 2'd0; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_regs("reset");
        check("reset_status", rd_last[2], 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: 75/925, capture visible exactly 3 cycles after the 2nd rise
        bus_write(2'd3, 32'h1);
        repeat (5) tick();
        pwm_period(75, 925);
        pwm_in = 1'b1;
        tick(); tick();
        check_regs("t1_pre");
        check("t1_not_yet", rd_last[2], 32'd0);
        tick();
        check_regs("t1");
        check("t1_high", rd_last[0], 32'd75);
        check("t1_period", rd_last[1], 32'd1000);
        check("t1_status", rd_last[2], 32'h1);

        // 2: stuck low after a capture -> timeout 2000 cycles after the rise
        bus_write(2'd3, 32'h3);
        bus_write(2'd2, 32'h7);
        repeat (70) tick();
        pwm_in = 1'b0;
        repeat (2002 - 75) tick();
        check_regs("t2_pre");
        check("t2_no_to_yet", rd_last[2], 32'd0);
        tick();
        check_regs("t2_to");
        check("t2_status", rd_last[2], 32'h2);
        tick();
        check_regs("t2_irq");
        check("t2_irq_high", {31'd0, bus.irq}, 32'd1);

        // 3: two periods without clearing -> overrun, newest data
        bus_write(2'd2, 32'h7);
        pwm_period(100, 400);
        check_regs("t3_idle");
        check("t3_idle_no_cap", rd_last[2], 32'd0);
        pwm_period(200, 300);
        pwm_in = 1'b1;
        repeat (3) tick();
        check_regs("t3");
        check("t3_status", rd_last[2], 32'h5);
        check("t3_high", rd_last[0], 32'd200);
        check("t3_period", rd_last[1], 32'd500);

        // 4: W1C of VALID in the capture cycle loses against the set
        bus_write(2'd2, 32'h4);
        repeat (196) tick();
        check_regs("t4_pre");
        check("t4_ovr_cleared", rd_last[2], 32'h1);
        pwm_in = 1'b0;
        repeat (300) tick();
        pwm_in = 1'b1;
        tick(); tick();
        bus_write(2'd2, 32'h1);
        check_regs("t4");
        check("t4_status", rd_last[2], 32'h5);
        check("t4_high", rd_last[0], 32'd200);

        // 5: reset mid-HIGH clears everything immediately
        repeat (10) tick();
        check_regs("t5_pre");
        check("t5_pre_irq", {31'd0, bus.irq}, 32'd1);
        reset_n = 1'b0;
        pwm_in = 1'b0;
        check_regs("t5_rst");
        for (int a = 0; a < 4; a++) check($sformatf("t5_zero%0d", a), rd_last[a], 32'd0);
        check("t5_irq_zero", {31'd0, bus.irq}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (2) tick();
        bus_write(2'd3, 32'h3);
        pwm_period(20, 30);
        check_regs("t5_first");
        check("t5_no_cap_1st", rd_last[2], 32'd0);
        pwm_in = 1'b1;
        repeat (3) tick();
        check_regs("t5_cap");
        check("t5_status", rd_last[2], 32'h1);
        check("t5_high", rd_last[0], 32'd20);
        check("t5_period", rd_last[1], 32'd50);

        // 6: disable mid-period keeps results; re-enable, 1-cycle pulses
        repeat (5) tick();
        bus_write(2'd3, 32'h2);
        repeat (11) tick();
        pwm_in = 1'b0;
        repeat (30) tick();
        repeat (3) pwm_period(1, 49);
        check_regs("t6_dis");
        check("t6_kept_high", rd_last[0], 32'd20);
        check("t6_kept_period", rd_last[1], 32'd50);
        bus_write(2'd0, 32'hFFF);
        bus_write(2'd2, 32'h7);
        bus_write(2'd3, 32'h3);
        check_regs("t6_wr_ign");
        check("t6_wr_ignored", rd_last[0], 32'd20);
        pwm_period(1, 49);
        pwm_in = 1'b1;
        repeat (3) tick();
        check_regs("t6");
        check("t6_high", rd_last[0], 32'd1);
        check("t6_period", rd_last[1], 32'd50);
        check("t6_status", rd_last[2], 32'h1);

        // table of pulse shapes
        for (int i = 0; i < 6; i++) begin
            pwm_in = 1'b0;
            bus_write(2'd2, 32'h7);
            tick();
            pwm_period(vecs[i].hi, vecs[i].lo);
            pwm_period(vecs[i].hi, vecs[i].lo);
            pwm_in = 1'b1;
            repeat (3) tick();
            check_regs($sformatf("vec%0d", i));
            check($sformatf("vec%0d_high", i), rd_last[0], vecs[i].exp_high);
            check($sformatf("vec%0d_period", i), rd_last[1], vecs[i].exp_period);
        end

        // randomized pulses, stalls and register writes
        begin
            int run;
            logic [31:0] d;
            logic [1:0]  a;
            run = 0;
            for (int i = 0; i < 6000; i++) begin
                if (run == 0) begin
                    pwm_in = ~pwm_in;
                    run = ($urandom_range(0, 199) == 0) ? 2100 : int'($urandom_range(1, 40));
                end
                run--;
                if ($urandom_range(0, 29) == 0) begin
                    a = 2'($urandom_range(0, 3));
                    d = $urandom;
                    if (a == 2'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
                    bus_write(a, d);
                end else begin
                    tick();
                end
                if (i % 16 == 0) check_regs("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
